// File: rtl/mac_pkg.sv
// Shared MAC datapath definitions: FSM encoding and default widths used by
// the multiplier, the accumulator and the result sink.
package mac_pkg;

  localparam int MAC_PROD_W = 36;
  localparam int MAC_ACC_W  = 48;
  localparam int MAC_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } mac_state_e;

endpackage

// File: rtl/mac_sat_add.sv
// Combinational accumulate step: extend the product, add it to the signed
// accumulator one bit wider than ACC_W, detect signed overflow and either
// clamp or wrap the result.
module mac_sat_add #(
  parameter int PROD_W = 36,
  parameter int ACC_W  = 48,
  parameter int SAT_EN = 1
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_signed,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W:0] prod_ext;
  logic [ACC_W:0] acc_ext;
  logic [ACC_W:0] sum_wide;

  // The extra top bit keeps the true sum exact; overflow is when its two
  // upper bits disagree, i.e. the value no longer fits ACC_W signed bits.
  always_comb begin
    prod_ext = prod_signed ? {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod}
                           : {{(ACC_W+1-PROD_W){1'b0}}, prod};
    acc_ext  = {acc[ACC_W-1], acc};
    sum_wide = acc_ext + prod_ext;
    ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    sum      = sum_wide[ACC_W-1:0];
    if (ovf && (SAT_EN != 0))
      sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                            : {1'b0, {(ACC_W-1){1'b1}}};
  end

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates a programmed number of multiplier products and presents the
// result on a valid/ready port. All handshake outputs are registered.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W = MAC_PROD_W,
  parameter int ACC_W  = MAC_ACC_W,
  parameter int CNT_W  = MAC_CNT_W,
  parameter int SAT_EN = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_len,
  input  logic              i_prod_signed,
  input  logic [PROD_W-1:0] i_prod,
  input  logic              i_prod_valid,
  output logic              o_prod_ready,
  output logic [ACC_W-1:0]  o_acc,
  output logic              o_acc_valid,
  input  logic              i_acc_ready,
  output logic              o_ovf,
  output logic              o_busy
);

  mac_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;
  logic             xfer;

  assign xfer = i_prod_valid & o_prod_ready;

  mac_sat_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W),
    .SAT_EN (SAT_EN)
  ) u_add (
    .acc         (o_acc),
    .prod        (i_prod),
    .prod_signed (i_prod_signed),
    .sum         (sum),
    .ovf         (add_ovf)
  );

  // Job FSM; o_acc doubles as the accumulator so it holds after the handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      o_acc        <= '0;
      o_ovf        <= 1'b0;
      o_prod_ready <= 1'b0;
      o_acc_valid  <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            o_acc  <= '0;
            o_ovf  <= 1'b0;
            cnt    <= i_len;
            o_busy <= 1'b1;
            if (i_len == '0) begin
              state       <= ST_DONE;
              o_acc_valid <= 1'b1;
            end else begin
              state        <= ST_ACC;
              o_prod_ready <= 1'b1;
            end
          end
        end
        ST_ACC: begin
          if (xfer) begin
            o_acc <= sum;
            if (add_ovf) o_ovf <= 1'b1;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              state        <= ST_DONE;
              o_prod_ready <= 1'b0;
              o_acc_valid  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (i_acc_ready) begin
            state       <= ST_IDLE;
            o_acc_valid <= 1'b0;
            o_busy      <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          o_prod_ready <= 1'b0;
          o_acc_valid  <= 1'b0;
          o_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: three instances (48-bit saturating,
// 38-bit saturating, 38-bit wrapping) share one stimulus stream.
module tb_mac_accumulator;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [15:0] i_len;
  logic        i_prod_signed;
  logic [35:0] i_prod;
  logic        i_prod_valid;
  logic        i_acc_ready;

  logic        rdy0, rdy1, rdy2, vld0, vld1, vld2, ovf0, ovf1, ovf2, bsy0, bsy1, bsy2;
  logic [47:0] acc0;
  logic [37:0] acc1, acc2;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  logic [5:0][35:0] prods;
  logic [5:0]       sgns;

  always #5 i_clk = ~i_clk;

  mac_accumulator dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_len(i_len),
    .i_prod_signed(i_prod_signed), .i_prod(i_prod), .i_prod_valid(i_prod_valid),
    .o_prod_ready(rdy0), .o_acc(acc0), .o_acc_valid(vld0), .i_acc_ready(i_acc_ready),
    .o_ovf(ovf0), .o_busy(bsy0));

  mac_accumulator #(.ACC_W(38), .SAT_EN(1)) dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_len(i_len),
    .i_prod_signed(i_prod_signed), .i_prod(i_prod), .i_prod_valid(i_prod_valid),
    .o_prod_ready(rdy1), .o_acc(acc1), .o_acc_valid(vld1), .i_acc_ready(i_acc_ready),
    .o_ovf(ovf1), .o_busy(bsy1));

  mac_accumulator #(.ACC_W(38), .SAT_EN(0)) dut2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_len(i_len),
    .i_prod_signed(i_prod_signed), .i_prod(i_prod), .i_prod_valid(i_prod_valid),
    .o_prod_ready(rdy2), .o_acc(acc2), .o_acc_valid(vld2), .i_acc_ready(i_acc_ready),
    .o_ovf(ovf2), .o_busy(bsy2));

  // Count accepted products on dut0 independently of the driver.
  always @(posedge i_clk) if (i_prod_valid && rdy0) xfers <= xfers + 1;

  function automatic logic [47:0] acc_of(input int sel);
    case (sel)
      1:       return {10'b0, acc1};
      2:       return {10'b0, acc2};
      default: return acc0;
    endcase
  endfunction

  function automatic logic ovf_of(input int sel);
    case (sel)
      1:       return ovf1;
      2:       return ovf2;
      default: return ovf0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start a job, feed len products, check valid latency, optionally stall the
  // result port while poking i_start and i_prod_valid, then complete it.
  task automatic run_job(input string name, input int len, input int sel,
                         input logic [47:0] exp_acc, input logic exp_ovf,
                         input bit rnd, input int stall);
    int k;
    int cyc;
    int x0;
    logic [47:0] held;
    x0 = xfers;
    @(negedge i_clk);
    i_start = 1'b1;
    i_len   = 16'(len);
    @(negedge i_clk);
    i_start = 1'b0;
    k = 0;
    cyc = 0;
    while (k < len && cyc < 200) begin
      if (rdy0) begin
        i_prod_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        i_prod        = prods[k];
        i_prod_signed = sgns[k];
        if (i_prod_valid) k++;
      end else begin
        i_prod_valid = 1'b0;
      end
      @(negedge i_clk);
      cyc++;
    end
    chk({name, " feed_timeout"}, 48'(cyc >= 200), 48'd0);
    i_prod_valid = (stall > 0);
    chk({name, " valid_lat"}, 48'(vld0), 48'd1);
    chk({name, " acc"}, acc_of(sel), exp_acc);
    chk({name, " ovf"}, 48'(ovf_of(sel)), 48'(exp_ovf));
    held = acc_of(sel);
    for (int s = 0; s < stall; s++) begin
      i_start = 1'b1;
      @(negedge i_clk);
      chk({name, " stall_acc"}, acc_of(sel), held);
      chk({name, " stall_rdy"}, 48'({rdy0, vld0}), 48'b01);
    end
    i_acc_ready = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_prod_valid = 1'b0;
    chk({name, " post_valid"}, 48'({vld0, bsy0}), 48'd0);
    chk({name, " post_acc"}, acc_of(sel), held);
    @(negedge i_clk);
    chk({name, " idle_after"}, 48'({bsy0, rdy0}), 48'd0);
    chk({name, " xfers"}, 48'(xfers - x0), 48'(len));
  endtask

  typedef struct {
    string            name;
    int               len;
    logic [5:0][35:0] p;
    logic [5:0]       sg;
    int               sel;
    logic [47:0]      exp_acc;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"unsigned",  3, {36'd0, 36'd0, 36'd0, 36'd30, 36'd20, 36'd10}, 6'b0,     0, 48'd60, 1'b0};
    vecs[1] = '{"signed",    2, {144'd0, 36'd5, 36'hF_FFFF_FFFF}, 6'b000011,          0, 48'd4, 1'b0};
    vecs[2] = '{"unsig_ff",  2, {144'd0, 36'd5, 36'hF_FFFF_FFFF}, 6'b000000,          0, 48'h10_0000_0004, 1'b0};
    vecs[3] = '{"sat_pos",   5, {36'd0, {5{36'h7_FFFF_FFFF}}}, 6'b011111,             1, 48'h1F_FFFF_FFFF, 1'b1};
    vecs[4] = '{"wrap_pos",  5, {36'd0, {5{36'h7_FFFF_FFFF}}}, 6'b011111,             2, 48'h27_FFFF_FFFB, 1'b1};
    vecs[5] = '{"mixed",     2, {144'd0, 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF}, 6'b000001, 0, 48'hF_FFFF_FFFE, 1'b0};
    vecs[6] = '{"sat_neg",   5, {36'd0, {5{36'h8_0000_0000}}}, 6'b011111,             1, 48'h20_0000_0000, 1'b1};
    vecs[7] = '{"sat_then",  4, {72'd0, 36'hF_FFFF_FFFF, {3{36'hF_FFFF_FFFF}}}, 6'b001000, 1, 48'h1F_FFFF_FFFE, 1'b1};

    i_rst = 1'b1; i_start = 1'b0; i_len = '0; i_prod_signed = 1'b0;
    i_prod = '0; i_prod_valid = 1'b0; i_acc_ready = 1'b1;
    prods = '0; sgns = '0;
    repeat (2) @(negedge i_clk);
    chk("reset_outs", {acc0[31:0], 12'd0, rdy0, vld0, ovf0, bsy0}, 48'd0);
    i_rst = 1'b0;

    foreach (vecs[i]) begin
      prods = vecs[i].p;
      sgns  = vecs[i].sg;
      run_job(vecs[i].name, vecs[i].len, vecs[i].sel, vecs[i].exp_acc, vecs[i].exp_ovf, 1'b0, 0);
    end

    // Same data as sat_then on the wrapping instance: no clamp, ovf still set.
    prods = vecs[7].p; sgns = vecs[7].sg;
    run_job("wrap_then", 4, 2, 48'h2F_FFFF_FFFC, 1'b1, 1'b0, 0);

    // Backpressure: random valid, result stalled 3 cycles, start/valid ignored.
    prods = {72'd0, 36'd4, 36'd3, 36'd2, 36'd1}; sgns = '0;
    i_acc_ready = 1'b0;
    run_job("backpress", 4, 0, 48'd10, 1'b0, 1'b1, 3);

    // Reset mid-job: partial sum and flags cleared without a clock edge.
    @(negedge i_clk);
    i_start = 1'b1; i_len = 16'd4;
    @(negedge i_clk);
    i_start = 1'b0;
    i_prod_valid = 1'b1; i_prod = 36'd100; i_prod_signed = 1'b0;
    @(negedge i_clk);
    i_prod = 36'd200;
    @(negedge i_clk);
    i_prod_valid = 1'b0;
    chk("mid_partial", acc0, 48'd300);
    #2 i_rst = 1'b1;
    #1 chk("rst_async", {acc0[31:0], 12'd0, rdy0, vld0, ovf0, bsy0}, 48'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    prods = {180'd0, 36'd7}; sgns = '0;
    run_job("after_rst", 1, 0, 48'd7, 1'b0, 1'b0, 0);

    // Zero length: straight to DONE, result 0, nothing consumed.
    @(negedge i_clk);
    i_start = 1'b1; i_len = 16'd0; i_prod_valid = 1'b1; i_prod = 36'd9;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("len0_valid", 48'({vld0, rdy0}), 48'b10);
    chk("len0_acc", acc0, 48'd0);
    @(negedge i_clk);
    i_prod_valid = 1'b0;
    chk("len0_done", 48'({vld0, rdy0, bsy0}), 48'd0);
    chk("len0_acc_hold", acc0, 48'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
